// File: rtl/dt_vote_accum_pkg.sv
// Shared definitions for the decision-tree classifier back end.
package dt_pkg;
  localparam int NUM_CLASSES = 18;
  localparam int IDX_W       = $clog2(NUM_CLASSES);

  typedef logic [NUM_CLASSES-1:0] class_vec_t;
  typedef logic [IDX_W-1:0]       class_idx_t;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    OUT   = 2'd2
  } state_e;

  // Width needed to hold a count of 0..window inclusive.
  function automatic int cnt_width(input int window);
    return $clog2(window + 1);
  endfunction
endpackage

// File: rtl/dt_vote_accum_if.sv
// Input vector and result handshakes of the vote accumulator.
interface dt_vote_accum_if #(parameter int WINDOW = 16);
  import dt_pkg::*;
  localparam int CNT_W = cnt_width(WINDOW);

  logic             in_valid;
  logic             in_ready;
  class_vec_t       in_vec;
  logic             out_valid;
  logic             out_ready;
  class_idx_t       out_class;
  logic [CNT_W-1:0] out_count;
  logic             out_tie;

  // Upstream classifier and downstream readout side.
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_class, out_count, out_tie
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_class, out_count, out_tie
  );
endinterface

// File: rtl/dt_vote_accum_class_counter.sv
// Per-class hit counter, saturating at MAX, with synchronous clear.
module dt_class_counter #(
  parameter int CNT_W = 5,
  parameter int MAX   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

  // Clear wins over increment; the saturation guard should never trigger
  // because a window holds at most MAX samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt <= '0;
    else if (clr)                    cnt <= '0;
    else if (inc && cnt != CNT_MAX)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/dt_vote_accum.sv
// Accumulates per-class votes over WINDOW samples, then scans the counters
// one class per cycle for the argmax and presents it on a valid/ready port.
module dt_vote_accum
  import dt_pkg::*;
#(
  parameter int WINDOW = 16
) (
  input  logic          clk,
  input  logic          rst,
  dt_vote_accum_if.slave bus
);
  localparam int               CNT_W    = cnt_width(WINDOW);
  localparam class_idx_t       LAST_IDX = class_idx_t'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  state_e                             state, next_state;
  logic                               in_ready, out_valid;
  logic                               accept, deliver, last_sample, scan_last;
  logic [CNT_W-1:0]                   sample_cnt;
  logic [NUM_CLASSES-1:0][CNT_W-1:0]  cnt;
  class_idx_t                         idx;
  logic [CNT_W-1:0]                   cur;

  class_idx_t                         best, nbest;
  logic [CNT_W-1:0]                   best_cnt, nbest_cnt;
  logic                               tie, ntie;

  class_idx_t                         out_class;
  logic [CNT_W-1:0]                   out_count;
  logic                               out_tie;

  assign accept      = bus.in_valid && in_ready;
  assign deliver     = out_valid && bus.out_ready;
  assign last_sample = accept && (sample_cnt == WIN_LAST);
  assign scan_last   = (state == SCAN) && (idx == LAST_IDX);

  // Per-class counters.
  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
    dt_class_counter #(.CNT_W(CNT_W), .MAX(WINDOW)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (accept && bus.in_vec[g]),
      .clr (deliver),
      .cnt (cnt[g])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= next_state;
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ACCUM:   if (last_sample)   next_state = SCAN;
      SCAN:    if (scan_last)     next_state = OUT;
      OUT:     if (bus.out_ready) next_state = ACCUM;
      default:                    next_state = ACCUM;
    endcase
  end

  // FSM outputs: handshake flags follow the state directly.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM:   in_ready  = 1'b1;
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  // Samples taken in the current window; an all-zero vector still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          sample_cnt <= '0;
    else if (deliver) sample_cnt <= '0;
    else if (accept)  sample_cnt <= sample_cnt + 1'b1;
  end

  // Scan index walks 0..NUM_CLASSES-1 while scanning, parked at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            idx <= '0;
    else if (state == SCAN && !scan_last) idx <= idx + 1'b1;
    else                                idx <= '0;
  end

  // Counter read mux plus one argmax step; lower index wins ties.
  always_comb begin
    cur       = cnt[idx];
    nbest     = best;
    nbest_cnt = best_cnt;
    ntie      = tie;
    if (cur > best_cnt) begin
      nbest     = idx;
      nbest_cnt = cur;
      ntie      = 1'b0;
    end else if (cur == best_cnt && best_cnt != '0) begin
      ntie      = 1'b1;
    end
  end

  // Running argmax, reset when a new scan starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best     <= '0;
      best_cnt <= '0;
      tie      <= 1'b0;
    end else if (last_sample) begin
      best     <= '0;
      best_cnt <= '0;
      tie      <= 1'b0;
    end else if (state == SCAN) begin
      best     <= nbest;
      best_cnt <= nbest_cnt;
      tie      <= ntie;
    end
  end

  // Result registers load only on OUT entry, so they hold across later windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_class <= '0;
      out_count <= '0;
      out_tie   <= 1'b0;
    end else if (scan_last) begin
      out_class <= nbest;
      out_count <= nbest_cnt;
      out_tie   <= ntie;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_class = out_class;
  assign bus.out_count = out_count;
  assign bus.out_tie   = out_tie;
endmodule

// File: tb/tb_dt_vote_accum.sv
// Directed bench for dt_vote_accum.
module tb_dt_vote_accum;
  import dt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   edges;

  dt_vote_accum_if #(.WINDOW(16)) bus ();

  dt_vote_accum #(.WINDOW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one vector from a falling edge and hold it until accepted.
  task automatic send(input class_vec_t v);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_vec   = '0;
  endtask

  // Count rising edges until out_valid, bounded.
  task automatic wait_out(output int e);
    e = 0;
    while (!bus.out_valid && e < 100) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input int cls, input int cnt, input int tie);
    chk({tag, "_valid"}, 32'(bus.out_valid), 1);
    chk({tag, "_class"}, 32'(bus.out_class), 32'(cls));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(cnt));
    chk({tag, "_tie"},   32'(bus.out_tie),   32'(tie));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_out_class"}, 32'(bus.out_class), 0);
    chk({tag, "_out_count"}, 32'(bus.out_count), 0);
    chk({tag, "_out_tie"},   32'(bus.out_tie),   0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    #12;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: sixteen bit5 votes, latency of 18 edges.
    for (int i = 0; i < 16; i++) send(18'h00020);
    chk("t1_scan_in_ready", 32'(bus.in_ready), 0);
    wait_out(edges);
    chk("t1_latency", 32'(edges), 18);
    check_result("t1", 5, 16, 0);
    take();
    chk("t1_after_valid", 32'(bus.out_valid), 0);
    chk("t1_after_ready", 32'(bus.in_ready), 1);

    // 2: tie between bit3 and bit9, lower index wins.
    for (int i = 0; i < 8; i++) send(18'h00008);
    for (int i = 0; i < 8; i++) send(18'h00200);
    wait_out(edges);
    chk("t2_latency", 32'(edges), 18);
    check_result("t2", 3, 8, 1);
    take();

    // 4: multi-hot, bit17 every sample, bit0 in ten of them.
    for (int i = 0; i < 16; i++) send(i < 10 ? 18'h20001 : 18'h20000);
    wait_out(edges);
    check_result("t4", 17, 16, 0);

    // 5: stall in OUT for five cycles while upstream pulses valid.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_vec   = 18'h00002;
      #1;
      chk("t5_in_ready", 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      check_result("t5_hold", 17, 16, 0);
    end
    bus.in_valid = 1'b0;
    bus.in_vec   = '0;
    take();
    chk("t5_released", 32'(bus.out_valid), 0);

    // 3: all-zero window; also shows the previous counts and the stalled
    // pulses left nothing behind.
    for (int i = 0; i < 16; i++) send('0);
    wait_out(edges);
    chk("t3_latency", 32'(edges), 18);
    check_result("t3", 0, 0, 0);
    take();

    // 6: reset after seven accepts.
    for (int i = 0; i < 7; i++) send(18'h00001);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("t6_mid_window");
    @(negedge clk);
    rst = 1'b0;

    // Reset again during a scan.
    for (int i = 0; i < 16; i++) send(18'h00002);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t6_in_scan", 32'(bus.in_ready), 0);
    rst = 1'b1;
    #1;
    check_reset("t6_mid_scan");
    @(negedge clk);
    rst = 1'b0;

    // Fresh window: stale bit0/bit1 counts would change the result.
    for (int i = 0; i < 16; i++) send(18'h00004);
    wait_out(edges);
    chk("t6_latency", 32'(edges), 18);
    check_result("t6", 2, 16, 0);
    take();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
